// File: rtl/instr_fetch_pkg.sv
// Shared widths, queue entry layout and PC helper for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned IMEM_AW     = 16;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned FETCH_DEPTH = 4;

  // One prefetch queue entry: {pc, instr}
  typedef struct packed {
    logic [IMEM_AW-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetchEntry_t;

  // Sequential fetch address; wraps naturally at the top of the address space
  function automatic logic [IMEM_AW-1:0] pcInc(input logic [IMEM_AW-1:0] pc);
    return pc + IMEM_AW'(1);
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch queue. Entry 0 is always the head so the decoder sees plain registers;
// the head keeps its last value when the queue drains or is flushed.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetchEntry_t   din,
  output fetchEntry_t   head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetchEntry_t         entries [DEPTH];
  logic                doPop;
  logic                doPush;
  logic [CW-1:0]       cntNext;
  logic [AW-1:0]       wrIdx;

  assign head = entries[0];

  // Qualify requests against current occupancy and compute the next count
  always_comb begin
    doPop   = pop & ~empty;
    doPush  = push & (~full | doPop);
    wrIdx   = AW'(count - CW'(doPop));
    cntNext = count;
    if (flush) begin
      cntNext = '0;
    end else begin
      cntNext = count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage shift on pop, write behind the last live entry on push; flush only clears occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= cntNext;
      empty <= (cntNext == '0);
      full  <= (cntNext == CW'(DEPTH));
      if (!flush) begin
        if (doPop) begin
          for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (CW'(i + 1) < count) begin
              entries[i] <= entries[i+1];
            end
          end
        end
        if (doPush) begin
          entries[wrIdx] <= din;
        end
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory requests feeding a prefetch queue,
// with redirect flush, stale-response discard and permanent halt.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [IMEM_AW-1:0] RESET_PC = 16'h0000,
  parameter int unsigned        DEPTH    = FETCH_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [IMEM_AW-1:0] instr_pc,
  output logic               instr_valid,
  input  logic               dec_ready,
  input  logic               hlt,
  input  logic               redir,
  input  logic [IMEM_AW-1:0] redir_pc,
  output logic               halted
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [IMEM_AW-1:0] fetchPc;
  logic               discard;

  logic               xfer;
  logic               pop;
  logic               haltNow;
  logic               redirTake;
  logic               flush;
  logic               push;
  logic               reqHold;
  logic               spaceNext;
  logic               haltedNext;
  logic               discardNext;
  logic               reqNext;
  logic [IMEM_AW-1:0] fetchPcNext;
  logic [IMEM_AW-1:0] addrNext;
  logic               almostFull;

  fetchEntry_t        pushEntry;
  fetchEntry_t        headEntry;
  logic [CW-1:0]      fifoCount;
  logic               fifoEmpty;
  logic               fifoFull;

  assign pushEntry   = '{pc: imem_addr, instr: imem_rdata};
  assign instr       = headEntry.instr;
  assign instr_pc    = headEntry.pc;
  assign instr_valid = ~fifoEmpty;

  instr_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (pushEntry),
    .head  (headEntry),
    .count (fifoCount),
    .empty (fifoEmpty),
    .full  (fifoFull)
  );

  // Next-state for request, PC, discard and halt; halt beats redirect beats push/pop
  always_comb begin
    xfer        = imem_req & imem_ack;
    pop         = instr_valid & dec_ready;
    haltNow     = pop & hlt & ~halted;
    redirTake   = redir & ~halted & ~haltNow;
    flush       = halted | haltNow | redirTake;
    push        = xfer & ~discard & ~flush;
    haltedNext  = halted | haltNow;
    almostFull  = (fifoCount == CW'(DEPTH - 1));
    spaceNext   = flush |
                  ~((fifoFull & (~pop | push)) | (almostFull & push & ~pop));

    discardNext = discard;
    if (xfer) begin
      discardNext = 1'b0;
    end
    if (redirTake && imem_req && !imem_ack) begin
      discardNext = 1'b1;
    end

    fetchPcNext = fetchPc;
    if (push) begin
      fetchPcNext = pcInc(imem_addr);
    end
    if (redirTake) begin
      fetchPcNext = redir_pc;
    end

    reqHold  = imem_req & ~imem_ack;
    reqNext  = reqHold | (~haltedNext & spaceNext);
    addrNext = reqHold ? imem_addr : fetchPcNext;
  end

  // Fetch control registers; the request port is driven only from these
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetchPc   <= RESET_PC;
      discard   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      imem_req  <= reqNext;
      imem_addr <= addrNext;
      fetchPc   <= fetchPcNext;
      discard   <= discardNext;
      halted    <= haltedNext;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for streaming, backpressure,
// redirect and halt entry, plus hand sequences for halt hold, wrap and async reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemRdata;
  logic [15:0] instr;
  logic [15:0] instrPc;
  logic        instrValid;
  logic        decReady;
  logic        hlt;
  logic        redir;
  logic [15:0] redirPc;
  logic        halted;

  logic        rstW_n;
  logic        reqW;
  logic [15:0] addrW;
  logic [15:0] rdataW;
  logic [15:0] instrW;
  logic [15:0] pcW;
  logic        validW;
  logic        haltedW;
  logic        ackW = 1'b1;
  logic        readyW = 1'b1;
  logic        hltW = 1'b0;
  logic        redirW = 1'b0;
  logic [15:0] redirPcW = 16'h0000;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imemRdata = imemAddr ^ 16'hA5A5;
  assign rdataW    = addrW ^ 16'hA5A5;

  instr_fetch #(.RESET_PC(16'h0000), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imemAck), .imem_rdata(imemRdata),
    .instr(instr), .instr_pc(instrPc), .instr_valid(instrValid),
    .dec_ready(decReady), .hlt(hlt), .redir(redir), .redir_pc(redirPc), .halted(halted)
  );

  instr_fetch #(.RESET_PC(16'hFFFE), .DEPTH(4)) dutW (
    .clk(clk), .rst_n(rstW_n),
    .imem_req(reqW), .imem_addr(addrW), .imem_ack(ackW), .imem_rdata(rdataW),
    .instr(instrW), .instr_pc(pcW), .instr_valid(validW),
    .dec_ready(readyW), .hlt(hltW), .redir(redirW), .redir_pc(redirPcW), .halted(haltedW)
  );

  typedef struct {
    logic        rs;
    logic        ack;
    logic        dr;
    logic        rd;
    logic [15:0] rpc;
    logic        hl;
    logic        eReq;
    logic [15:0] eAddr;
    logic        eValid;
    logic [15:0] ePc;
    logic        eHalt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rs, input logic ack, input logic dr, input logic rd,
                             input logic [15:0] rpc, input logic hl, input logic eReq,
                             input logic [15:0] eAddr, input logic eValid,
                             input logic [15:0] ePc, input logic eHalt);
    vec_t r;
    r.rs = rs; r.ack = ack; r.dr = dr; r.rd = rd; r.rpc = rpc; r.hl = hl;
    r.eReq = eReq; r.eAddr = eAddr; r.eValid = eValid; r.ePc = ePc; r.eHalt = eHalt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rstW_n = 1'b0;
    imemAck = 1'b0; decReady = 1'b0; hlt = 1'b0; redir = 1'b0; redirPc = '0;

    // Test 1: zero-wait stream
    vecs.push_back(v(1,1,1,0,16'h0,0, 0,16'h0000,0,16'h0000,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0000,0,16'h0000,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0001,1,16'h0000,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0002,1,16'h0001,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0003,1,16'h0002,0));
    vecs.push_back(v(0,1,0,0,16'h0,0, 1,16'h0004,1,16'h0003,0));
    // Test 2: backpressure fills queue, then drains with requests resuming at 4
    vecs.push_back(v(1,1,0,0,16'h0,0, 0,16'h0000,0,16'h0000,0));
    vecs.push_back(v(1,1,0,0,16'h0,0, 1,16'h0000,0,16'h0000,0));
    vecs.push_back(v(1,1,0,0,16'h0,0, 1,16'h0001,1,16'h0000,0));
    vecs.push_back(v(1,1,0,0,16'h0,0, 1,16'h0002,1,16'h0000,0));
    vecs.push_back(v(1,1,0,0,16'h0,0, 1,16'h0003,1,16'h0000,0));
    vecs.push_back(v(1,1,0,0,16'h0,0, 0,16'h0000,1,16'h0000,0));
    vecs.push_back(v(1,1,0,0,16'h0,0, 0,16'h0000,1,16'h0000,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 0,16'h0000,1,16'h0000,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0004,1,16'h0001,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0005,1,16'h0002,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0006,1,16'h0003,0));
    vecs.push_back(v(0,1,1,0,16'h0,0, 1,16'h0007,1,16'h0004,0));
    // Test 3: redirect while addr 5 is pending; its data is discarded
    vecs.push_back(v(1,1,1,0,16'h0,0, 0,16'h0000,0,16'h0000,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0000,0,16'h0000,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0001,1,16'h0000,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0002,1,16'h0001,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0003,1,16'h0002,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0004,1,16'h0003,0));
    vecs.push_back(v(1,0,1,1,16'h0040,0, 1,16'h0005,1,16'h0004,0));
    vecs.push_back(v(1,0,1,0,16'h0,0, 1,16'h0005,0,16'h0004,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0005,0,16'h0004,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0040,0,16'h0004,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0041,1,16'h0040,0));
    // Test 4: redirect on an edge that also acks and pops
    vecs.push_back(v(1,1,1,1,16'h0100,0, 1,16'h0042,1,16'h0041,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0100,0,16'h0041,0));
    vecs.push_back(v(1,1,1,0,16'h0,0, 1,16'h0101,1,16'h0100,0));
    // Test 5 entry: pop with hlt while an ack for 0x102 lands
    vecs.push_back(v(1,1,1,0,16'h0,1, 1,16'h0102,1,16'h0101,0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.req",    16'(imemReq),    16'h0);
    chk("reset.addr",   imemAddr,        16'h0000);
    chk("reset.valid",  16'(instrValid), 16'h0);
    chk("reset.instr",  instr,           16'h0000);
    chk("reset.pc",     instrPc,         16'h0000);
    chk("reset.halted", 16'(halted),     16'h0);
    chk("resetW.addr",  addrW,           16'hFFFE);

    foreach (vecs[k]) begin
      chk($sformatf("row%0d.req", k),    16'(imemReq),    16'(vecs[k].eReq));
      if (vecs[k].eReq) chk($sformatf("row%0d.addr", k), imemAddr, vecs[k].eAddr);
      chk($sformatf("row%0d.valid", k),  16'(instrValid), 16'(vecs[k].eValid));
      chk($sformatf("row%0d.pc", k),     instrPc,         vecs[k].ePc);
      if (vecs[k].eValid) chk($sformatf("row%0d.instr", k), instr, vecs[k].ePc ^ 16'hA5A5);
      chk($sformatf("row%0d.halted", k), 16'(halted),     16'(vecs[k].eHalt));
      rst_n    = vecs[k].rs;
      imemAck  = vecs[k].ack;
      decReady = vecs[k].dr;
      redir    = vecs[k].rd;
      redirPc  = vecs[k].rpc;
      hlt      = vecs[k].hl;
      step();
    end

    // Test 5: halted holds for 20 cycles, ignoring a redirect pulse
    hlt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halt%0d.req", i),    16'(imemReq),    16'h0);
      chk($sformatf("halt%0d.valid", i),  16'(instrValid), 16'h0);
      chk($sformatf("halt%0d.halted", i), 16'(halted),     16'h1);
      redir   = (i == 2);
      redirPc = 16'h0200;
      step();
    end
    redir = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("haltrst.halted", 16'(halted), 16'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("haltrst.req",  16'(imemReq), 16'h1);
    chk("haltrst.addr", imemAddr,     16'h0000);

    // Test 6: PC wrap from 0xFFFE and asynchronous reset mid-transfer
    rstW_n = 1'b1;
    step();
    chk("wrap.req0",  16'(reqW), 16'h1);
    chk("wrap.addr0", addrW,     16'hFFFE);
    step();
    chk("wrap.pc0",   pcW,       16'hFFFE);
    chk("wrap.val0",  16'(validW), 16'h1);
    chk("wrap.addr1", addrW,     16'hFFFF);
    step();
    chk("wrap.pc1",   pcW,       16'hFFFF);
    chk("wrap.addr2", addrW,     16'h0000);
    step();
    chk("wrap.pc2",   pcW,       16'h0000);
    chk("wrap.instr2", instrW,   16'hA5A5);
    rstW_n = 1'b0;
    #1;
    chk("async.req",   16'(reqW),   16'h0);
    chk("async.valid", 16'(validW), 16'h0);
    chk("async.addr",  addrW,       16'hFFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
